divider_scheduler: RTL

Shares one iterative divider core between the RAH divider apps (unsigned and signed lanes). It pops 48-bit operand packets from the per-app decoder queues and arbitrates round-robin between them. It issues each operation to the divider with the correct signedness, then writes the 48-bit result packet into the granted app's encoder write path. It sits between the `rah_decoder` read side and the `rah_encoder` write side, and replaces the per-app private divider instances.

---
 rtl/divider_scheduler_if.sv | 44 ++++
 rtl/divider_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/divider_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_scheduler_if : decoder-queue, encoder-write and divider-core bundle
//                        seen by the shared divider scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface divider_scheduler_if #(
   parameter int DATA_WIDTH = 48,
   parameter int NUM_REQ    = 2
);
   localparam int OW = DATA_WIDTH / 2;
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            q_empty;
   logic [NUM_REQ-1:0]            q_rd_en;
   logic [NUM_REQ*DATA_WIDTH-1:0] q_data;
   logic [NUM_REQ-1:0]            out_full;
   logic [NUM_REQ-1:0]            out_wr_en;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          div_start;
   logic                          div_signed;
   logic [OW-1:0]                 div_dividend;
   logic [OW-1:0]                 div_divisor;
   logic                          div_busy;
   logic                          div_done;
   logic [OW-1:0]                 div_quotient;
   logic [OW-1:0]                 div_remainder;
   logic [GW-1:0]                 grant_id;
   logic                          busy;
   logic [15:0]                   op_count;

   modport master (
      input  q_empty, q_data, out_full, div_busy, div_done, div_quotient, div_remainder,
      output q_rd_en, out_wr_en, out_data, div_start, div_signed, div_dividend,
             div_divisor, grant_id, busy, op_count
   );

   modport slave (
      output q_empty, q_data, out_full, div_busy, div_done, div_quotient, div_remainder,
      input  q_rd_en, out_wr_en, out_data, div_start, div_signed, div_dividend,
             div_divisor, grant_id, busy, op_count
   );
endinterface
`default_nettype wire

// File: rtl/divider_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_scheduler : round-robin sharing of one iterative divider between
//                     RAH divider app lanes (signed/unsigned per lane).
// Revision: 1.0
// ---------------------------------------------------------------------------
module divider_scheduler #(
   parameter int                 DATA_WIDTH  = 48,
   parameter int                 NUM_REQ     = 2,
   parameter logic [NUM_REQ-1:0] SIGNED_MASK = 2'b10
) (
   input logic                 clk,
   input logic                 rst,
   divider_scheduler_if.master bus
);
   localparam int OW = DATA_WIDTH / 2;
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_ISSUE = 3'd3,
      S_WAIT  = 3'd4,
      S_WRITE = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [GW-1:0]         r_grant;
   logic [GW-1:0]         r_last_grant;
   logic [GW-1:0]         w_pick;
   logic [GW-1:0]         w_idx;
   logic                  w_any;
   logic [NUM_REQ-1:0]    w_elig;
   logic [NUM_REQ-1:0]    w_rd_en;
   logic [NUM_REQ-1:0]    w_wr_en;
   logic [DATA_WIDTH-1:0] w_lane_data;
   logic [DATA_WIDTH-1:0] r_result;
   logic [OW-1:0]         r_dividend;
   logic [OW-1:0]         r_divisor;
   logic                  r_signed;
   logic [15:0]           r_op_count;
   logic                  w_start_fire;
   logic                  w_wr_fire;
   logic                  w_div_zero;

   assign w_elig       = ~bus.q_empty & ~bus.out_full;
   assign w_start_fire = (r_state == S_ISSUE) && !bus.div_busy;
   assign w_wr_fire    = (r_state == S_WRITE) && !bus.out_full[r_grant];
   assign w_div_zero   = (w_lane_data[OW-1:0] == '0);

   // Search upward from the lane after the last winner so contenders alternate.
   always_comb begin
      w_any  = 1'b0;
      w_pick = r_last_grant;
      w_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_any && w_elig[w_idx]) begin
            w_any  = 1'b1;
            w_pick = w_idx;
         end
      end
   end

   always_comb begin
      w_rd_en     = '0;
      w_wr_en     = '0;
      w_lane_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant == GW'(i)) begin
            w_rd_en[i]  = (r_state == S_READ);
            w_wr_en[i]  = w_wr_fire;
            w_lane_data = bus.q_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_READ;
         S_READ:  w_next = S_LATCH;
         S_LATCH: w_next = w_div_zero ? S_WRITE : S_ISSUE;
         S_ISSUE: if (w_start_fire) w_next = S_WAIT;
         S_WAIT:  if (bus.div_done) w_next = S_WRITE;
         S_WRITE: if (w_wr_fire) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant      <= '0;
         r_last_grant <= GW'(NUM_REQ - 1);
         r_dividend   <= '0;
         r_divisor    <= '0;
         r_signed     <= 1'b0;
         r_result     <= '0;
         r_op_count   <= '0;
      end else begin
         if (r_state == S_IDLE && w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
         end
         if (r_state == S_LATCH) begin
            r_dividend <= w_lane_data[DATA_WIDTH-1:OW];
            r_divisor  <= w_lane_data[OW-1:0];
            r_signed   <= SIGNED_MASK[r_grant];
            // Divide by zero bypasses the core: quotient all ones, remainder = dividend.
            if (w_div_zero) begin
               r_result <= {{OW{1'b1}}, w_lane_data[DATA_WIDTH-1:OW]};
            end
         end
         if (r_state == S_WAIT && bus.div_done) begin
            r_result <= {bus.div_quotient, bus.div_remainder};
         end
         if (w_wr_fire) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

   assign bus.q_rd_en      = w_rd_en;
   assign bus.out_wr_en    = w_wr_en;
   assign bus.out_data     = r_result;
   assign bus.div_start    = w_start_fire;
   assign bus.div_signed   = r_signed;
   assign bus.div_dividend = r_dividend;
   assign bus.div_divisor  = r_divisor;
   assign bus.grant_id     = r_grant;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.op_count     = r_op_count;

endmodule
`default_nettype wire
